block_dispatch_cu: RTL and testbench

Next-generation main control unit for the coprocessor. It reads matrix dimensions from the config word and scatters (row, column) block indexes in row-major order across P processors using a per-processor handshake. It handles a partial final round, tracks per-processor results, runs a result watchdog, and writes back a completion/error status word.

---
 rtl/block_dispatch_cu.sv | 198 +++++++++++++++++++
 tb/tb_block_dispatch_cu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatch_cu.sv
// Main control unit: scatters row-major (row, column) block indexes across P processors,
// collects per-processor results under a watchdog and writes back a completion/error status word.
module block_dispatch_cu #(
    parameter int P              = 4,
    parameter int INDEX_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic [31:0]              i_Config,
    input  logic [31:0]              i_Status,
    input  logic [P-1:0]             i_Indexes_Received,
    input  logic [P-1:0]             i_Result_Ready,
    output logic [INDEX_WIDTH-1:0]   o_Row_Index,
    output logic [INDEX_WIDTH-1:0]   o_Column_Index,
    output logic [P-1:0]             o_Indexes_Ready,
    output logic [31:0]              o_Status,
    output logic                     o_Write_Status_Enable,
    output logic                     o_Busy,
    output logic [2*INDEX_WIDTH-1:0] o_Blocks_Dispatched
);

    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int CW = 2 * INDEX_WIDTH;
    localparam logic [PW-1:0] LAST_PROC = PW'(P - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LIMIT =
        TIMEOUT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        READ_CONFIG,
        SCATTER,
        WAIT_RESULT,
        WRITE_STATUS
    } state_t;

    state_t state, state_nxt;

    logic [INDEX_WIDTH-1:0]   cfg_lambda;
    logic [INDEX_WIDTH-1:0]   cfg_gamma;
    logic [INDEX_WIDTH-1:0]   gamma_q;
    logic [INDEX_WIDTH:0]     col_inc;
    logic [CW-1:0]            remaining;
    logic [PW-1:0]            proc;
    logic [P-1:0]             assigned;
    logic [P-1:0]             done_mask;
    logic [P-1:0]             results;
    logic [TIMEOUT_WIDTH-1:0] watchdog;
    logic                     accept;
    logic                     last_offer;
    logic                     cfg_zero;
    logic                     round_done;
    logic                     wd_expired;
    logic                     status_load;
    logic                     flag_timeout;
    logic                     flag_cfg_err;
    logic                     unused_bits;

    assign cfg_lambda  = i_Config[INDEX_WIDTH-1:0];
    assign cfg_gamma   = i_Config[CW-1:INDEX_WIDTH];
    assign cfg_zero    = (cfg_lambda == '0) || (cfg_gamma == '0);
    assign accept      = (state == SCATTER) && ((i_Indexes_Received & o_Indexes_Ready) != '0);
    assign last_offer  = (proc == LAST_PROC) || (remaining == CW'(1));
    assign round_done  = (done_mask == assigned);
    assign wd_expired  = (TIMEOUT_CYCLES != 0) && (watchdog == WD_LIMIT);
    // Only processors holding a block this round may report; stray results are dropped.
    assign results     = i_Result_Ready & assigned;
    assign col_inc     = {1'b0, o_Column_Index} + (INDEX_WIDTH + 1)'(1);
    assign o_Busy      = (state != IDLE);
    assign unused_bits = ^{i_Config, i_Status[2:0]};

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        status_load  = 1'b0;
        flag_timeout = 1'b0;
        flag_cfg_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_Status[31]) state_nxt = READ_CONFIG;
            end
            READ_CONFIG: begin
                if (cfg_zero) begin
                    state_nxt    = WRITE_STATUS;
                    status_load  = 1'b1;
                    flag_cfg_err = 1'b1;
                end else begin
                    state_nxt = SCATTER;
                end
            end
            SCATTER: begin
                if (accept && last_offer) state_nxt = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                // Completion is tested first so it wins over a watchdog expiring in the same cycle.
                if (round_done) begin
                    if (remaining == '0) begin
                        state_nxt   = WRITE_STATUS;
                        status_load = 1'b1;
                    end else begin
                        state_nxt = SCATTER;
                    end
                end else if (wd_expired) begin
                    state_nxt    = WRITE_STATUS;
                    status_load  = 1'b1;
                    flag_timeout = 1'b1;
                end
            end
            WRITE_STATUS: state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // NOTE: all datapath registers take the async reset so an aborted job leaves no residue.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            gamma_q               <= '0;
            remaining             <= '0;
            proc                  <= '0;
            assigned              <= '0;
            done_mask             <= '0;
            watchdog              <= '0;
            o_Row_Index           <= '0;
            o_Column_Index        <= '0;
            o_Indexes_Ready       <= '0;
            o_Status              <= '0;
            o_Write_Status_Enable <= 1'b0;
            o_Blocks_Dispatched   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same clock edge.
            o_Write_Status_Enable <= status_load;
            if (status_load) begin
                o_Status <= {1'b0, i_Status[30:3], flag_timeout, flag_cfg_err, 1'b1};
            end

            case (state)
                READ_CONFIG: begin
                    gamma_q <= cfg_gamma;
                    if (!cfg_zero) begin
                        remaining           <= {{INDEX_WIDTH{1'b0}}, cfg_lambda} *
                                               {{INDEX_WIDTH{1'b0}}, cfg_gamma};
                        o_Row_Index         <= '0;
                        o_Column_Index      <= '0;
                        proc                <= '0;
                        assigned            <= '0;
                        done_mask           <= '0;
                        o_Blocks_Dispatched <= '0;
                        o_Indexes_Ready     <= P'(1);
                    end
                end

                SCATTER: begin
                    done_mask <= done_mask | results;
                    if (accept) begin
                        assigned[proc]      <= 1'b1;
                        remaining           <= remaining - CW'(1);
                        o_Blocks_Dispatched <= o_Blocks_Dispatched + CW'(1);
                        if (col_inc >= {1'b0, gamma_q}) begin
                            o_Column_Index <= '0;
                            o_Row_Index    <= o_Row_Index + INDEX_WIDTH'(1);
                        end else begin
                            o_Column_Index <= col_inc[INDEX_WIDTH-1:0];
                        end
                        if (last_offer) begin
                            o_Indexes_Ready <= '0;
                            watchdog        <= '0;
                        end else begin
                            o_Indexes_Ready <= o_Indexes_Ready << 1;
                            proc            <= proc + PW'(1);
                        end
                    end
                end

                WAIT_RESULT: begin
                    if (round_done && (remaining != '0)) begin
                        proc            <= '0;
                        o_Indexes_Ready <= P'(1);
                        assigned        <= '0;
                        done_mask       <= '0;
                        watchdog        <= '0;
                    end else begin
                        done_mask <= done_mask | results;
                        watchdog  <= watchdog + TIMEOUT_WIDTH'(1);
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_dispatch_cu.sv
// Bench for block_dispatch_cu: a row-major block-list model is checked against every offer and
// every status write, with a few hand-computed values pinning latency, status words and ordering.
module tb_block_dispatch_cu;

    localparam int P  = 4;
    localparam int IW = 8;
    localparam int TO = 8;

    logic            i_Clock = 1'b0;
    logic            i_Reset;
    logic [31:0]     i_Config;
    logic [31:0]     i_Status;
    logic [P-1:0]    i_Indexes_Received;
    logic [P-1:0]    i_Result_Ready;
    logic [IW-1:0]   o_Row_Index;
    logic [IW-1:0]   o_Column_Index;
    logic [P-1:0]    o_Indexes_Ready;
    logic [31:0]     o_Status;
    logic            o_Write_Status_Enable;
    logic            o_Busy;
    logic [2*IW-1:0] o_Blocks_Dispatched;

    block_dispatch_cu #(
        .P(P), .INDEX_WIDTH(IW), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(16)
    ) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Config(i_Config), .i_Status(i_Status),
        .i_Indexes_Received(i_Indexes_Received), .i_Result_Ready(i_Result_Ready),
        .o_Row_Index(o_Row_Index), .o_Column_Index(o_Column_Index),
        .o_Indexes_Ready(o_Indexes_Ready), .o_Status(o_Status),
        .o_Write_Status_Enable(o_Write_Status_Enable), .o_Busy(o_Busy),
        .o_Blocks_Dispatched(o_Blocks_Dispatched)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        int proc;
        int row;
        int col;
    } blk_t;

    blk_t        exp_q[$];
    blk_t        acc_log[$];
    blk_t        chk_head;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          strobes  = 0;
    bit          model_on = 1'b0;
    logic [31:0] exp_status = '0;
    logic [31:0] stat_pat   = 32'h2ABC_DEF6;

    always @(posedge i_Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole job as a flat list: block i goes to processor i%P at (i/gamma, i%gamma).
    task automatic model_start(input int lam, input int gam, input int code);
        exp_q.delete();
        acc_log.delete();
        strobes = 0;
        for (int i = 0; i < lam * gam; i++) begin
            blk_t b;
            b.proc = i % P;
            b.row  = i / gam;
            b.col  = i % gam;
            exp_q.push_back(b);
        end
        exp_status = {1'b0, stat_pat[30:3], code[2:0]};
        model_on   = 1'b1;
    endtask

    always @(negedge i_Clock) begin
        if (i_Reset && model_on) begin
            if (o_Indexes_Ready != '0) begin
                if (exp_q.size() == 0) begin
                    check("extra_offer", 32'(o_Indexes_Ready), 32'd0);
                end else begin
                    chk_head = exp_q[0];
                    check("offer_valid", 32'(o_Indexes_Ready), 32'(1) << chk_head.proc);
                    check("offer_row", 32'(o_Row_Index), 32'(chk_head.row));
                    check("offer_col", 32'(o_Column_Index), 32'(chk_head.col));
                    check("dispatched_count", 32'(o_Blocks_Dispatched), 32'(acc_log.size()));
                    if ((i_Indexes_Received & o_Indexes_Ready) != '0) begin
                        acc_log.push_back(chk_head);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (o_Write_Status_Enable) begin
                strobes++;
                check("status_word", o_Status, exp_status);
            end
        end
    end

    // Plays the processors: acks after ack_delay cycles (optionally noise on other bits),
    // pulses a result res_delay cycles after each accept unless that processor is dead.
    task automatic run_job(input int lam, input int gam, input int ack_delay, input int res_delay,
                           input logic [P-1:0] dead, input bit noise, input int exp_code,
                           input int exp_blocks, output int start_cyc, output int strobe_cyc,
                           output int last_ack_cyc);
        int           age       = 0;
        bit           prev_good = 1'b0;
        int           prev_proc = 0;
        bit           seen      = 1'b0;
        int           timer[P];
        logic [P-1:0] ack;
        logic [P-1:0] res;
        logic [P-1:0] rnd;
        for (int k = 0; k < P; k++) timer[k] = -1;
        start_cyc    = 0;
        strobe_cyc   = 0;
        last_ack_cyc = 0;
        model_start(lam, gam, exp_code);
        @(posedge i_Clock); #1;
        i_Config  = {16'hA5A5, gam[7:0], lam[7:0]};
        i_Status  = stat_pat | 32'h8000_0000;
        start_cyc = cyc;
        @(posedge i_Clock); #1;
        i_Status = stat_pat;
        check("busy_in_read_config", 32'(o_Busy), 32'd1);
        check("no_offer_in_read_config", 32'(o_Indexes_Ready), 32'd0);
        for (int t = 0; t < 4000 && !seen; t++) begin
            if (o_Write_Status_Enable) begin
                seen       = 1'b1;
                strobe_cyc = cyc;
            end else begin
                if (cyc == start_cyc + 2)
                    check("first_offer_latency", 32'(o_Indexes_Ready), (lam * gam != 0) ? 32'd1 : 32'd0);
                if (prev_good) begin
                    age = 0;
                    if (!dead[prev_proc]) timer[prev_proc] = res_delay;
                end
                res = '0;
                for (int k = 0; k < P; k++) begin
                    if (timer[k] == 0) begin
                        res[k]   = 1'b1;
                        timer[k] = -1;
                    end else if (timer[k] > 0) begin
                        timer[k]--;
                    end
                end
                rnd       = noise ? P'($urandom_range(0, (1 << P) - 1)) : '0;
                prev_good = 1'b0;
                if (o_Indexes_Ready != '0 && age >= ack_delay) begin
                    ack          = o_Indexes_Ready;
                    prev_good    = 1'b1;
                    last_ack_cyc = cyc;
                    for (int k = 0; k < P; k++) if (o_Indexes_Ready[k]) prev_proc = k;
                end else begin
                    ack = rnd & ~o_Indexes_Ready;
                    if (o_Indexes_Ready != '0) age++;
                end
                i_Indexes_Received = ack;
                i_Result_Ready     = res;
                @(posedge i_Clock); #1;
            end
        end
        i_Indexes_Received = '0;
        i_Result_Ready     = '0;
        if (!seen) check("status_strobe_seen", 32'd0, 32'd1);
        @(posedge i_Clock); #1;
        check("strobe_single_cycle", 32'(o_Write_Status_Enable), 32'd0);
        check("idle_after_status", 32'(o_Busy), 32'd0);
        check("status_held", o_Status, exp_status);
        check("strobe_count", 32'(strobes), 32'd1);
        if (exp_blocks >= 0) check("blocks_dispatched", 32'(o_Blocks_Dispatched), 32'(exp_blocks));
        if (exp_code == 1) check("all_blocks_offered", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int s_cyc;
        int w_cyc;
        int a_cyc;
        i_Reset            = 1'b0;
        i_Config           = '0;
        i_Status           = '0;
        i_Indexes_Received = '0;
        i_Result_Ready     = '0;
        repeat (2) @(posedge i_Clock);
        #1;
        check("rst_ready", 32'(o_Indexes_Ready), 32'd0);
        check("rst_row_col", 32'({o_Row_Index, o_Column_Index}), 32'd0);
        check("rst_status", o_Status, 32'd0);
        check("rst_strobe_busy", 32'({o_Write_Status_Enable, o_Busy}), 32'd0);
        check("rst_blocks", 32'(o_Blocks_Dispatched), 32'd0);
        i_Reset = 1'b1;

        // Abort mid-SCATTER after one accepted block.
        model_start(2, 2, 1);
        @(posedge i_Clock); #1;
        i_Config = {16'h0, 8'd2, 8'd2};
        i_Status = stat_pat | 32'h8000_0000;
        @(posedge i_Clock); #1;
        i_Status = stat_pat;
        @(posedge i_Clock); #1;
        i_Indexes_Received = 4'b0001;
        @(posedge i_Clock); #1;
        i_Indexes_Received = '0;
        check("abort_pre_blocks", 32'(o_Blocks_Dispatched), 32'd1);
        check("abort_pre_offer", 32'(o_Indexes_Ready), 32'd2);
        #2;
        i_Reset = 1'b0;
        #1;
        check("abort_ready", 32'(o_Indexes_Ready), 32'd0);
        check("abort_busy_strobe", 32'({o_Busy, o_Write_Status_Enable}), 32'd0);
        check("abort_blocks", 32'(o_Blocks_Dispatched), 32'd0);
        check("abort_row_col", 32'({o_Row_Index, o_Column_Index}), 32'd0);
        model_on = 1'b0;
        check("abort_no_strobe", 32'(strobes), 32'd0);
        repeat (2) @(posedge i_Clock);
        #1;
        i_Reset = 1'b1;

        run_job(2, 2, 0, 3, 4'b0000, 1'b0, 1, 4, s_cyc, w_cyc, a_cyc);
        check("success_status_literal", o_Status, 32'h2ABC_DEF1);
        check("log_2x2_blk2", 32'({acc_log[2].proc[7:0], acc_log[2].row[7:0], acc_log[2].col[7:0]}),
              32'h00_02_01_00);

        run_job(2, 3, 0, 3, 4'b0000, 1'b0, 1, 6, s_cyc, w_cyc, a_cyc);
        check("log_2x3_blk3", 32'({acc_log[3].proc[7:0], acc_log[3].row[7:0], acc_log[3].col[7:0]}),
              32'h00_03_01_00);
        check("log_2x3_blk4", 32'({acc_log[4].proc[7:0], acc_log[4].row[7:0], acc_log[4].col[7:0]}),
              32'h00_00_01_01);
        check("log_2x3_blk5", 32'({acc_log[5].proc[7:0], acc_log[5].row[7:0], acc_log[5].col[7:0]}),
              32'h00_01_01_02);

        run_job(0, 5, 0, 3, 4'b0000, 1'b0, 3, -1, s_cyc, w_cyc, a_cyc);
        check("cfg_err_latency", 32'(w_cyc - s_cyc), 32'd2);
        check("cfg_err_status_literal", o_Status, 32'h2ABC_DEF3);
        run_job(3, 0, 0, 3, 4'b0000, 1'b0, 3, -1, s_cyc, w_cyc, a_cyc);
        check("cfg_err_gamma_latency", 32'(w_cyc - s_cyc), 32'd2);

        run_job(2, 2, 0, 2, 4'b0100, 1'b0, 5, 4, s_cyc, w_cyc, a_cyc);
        check("timeout_latency", 32'(w_cyc - a_cyc), 32'd9);
        check("timeout_status_literal", o_Status, 32'h2ABC_DEF5);

        run_job(2, 3, 5, 0, 4'b0000, 1'b1, 1, 6, s_cyc, w_cyc, a_cyc);
        run_job(3, 5, 1, 2, 4'b0000, 1'b1, 1, 15, s_cyc, w_cyc, a_cyc);
        run_job(20, 13, 0, 0, 4'b0000, 1'b0, 1, 260, s_cyc, w_cyc, a_cyc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
